arbiter_puf_engine: RTL
=======================

Name: arbiter_puf_engine

Overview:
Parametrised, cycle-accurate digital model of an N-stage arbiter PUF with a request/response handshake.
- Evaluates the race one stage per clock using a fixed per-stage delay table.
- Produces a RESP_BITS-wide response from one challenge, using rotated sub-challenges.
- Majority-votes VOTES evaluations per bit and reports an instability mask.
- Successor to the single-stage arbiter_puf top; sits between the challenge source and the key/ID logic.

Parameters:
STAGES, 64, challenge width and number of race stages (>=2)
DELAY_W, 8, width of each per-stage delay value
RESP_BITS, 8, response bits produced per challenge (1..STAGES)
VOTES, 5, evaluations per response bit; odd, >=1
NOISE_EN, 1, 1 = add LFSR jitter at the arbiter; 0 = fully deterministic
NOISE_W, 2, jitter width in bits
SEED, 32'hACE12024, nonzero seed of the delay-table generator

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  challenge offered
req_ready  output  1  engine idle and able to accept
challenge  input  STAGES  challenge, sampled on acceptance
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
response  output  RESP_BITS  majority-voted response
resp_unstable  output  RESP_BITS  bit k = 1 if the votes for bit k were not unanimous
busy  output  1  high in RACE, ARB or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; req_ready=1; resp_valid=0; response=0; resp_unstable=0; busy=0.
  - Accumulators, counters and vote counts cleared; noise LFSR = 16'h0001.
- Delay table (elaboration constant):
  - 32-bit Galois LFSR: s0=SEED; s(n+1) = (s(n)>>1) ^ (s(n)[0] ? 32'hB4BCD35C : 0).
  - d_top[i] = s(2i+1)[DELAY_W-1:0]; d_bot[i] = s(2i+2)[DELAY_W-1:0].
- Noise LFSR: 16-bit, s' = (s>>1) ^ (s[0] ? 16'hB400 : 0). Steps every cycle when not in reset.
- Acceptance: req_valid & req_ready in IDLE latches challenge into ch_reg, then enters RACE. The latched value is ch_reg, and bit k uses sub-challenge c_k = ch_reg rotated left by k.
- States:
  - IDLE:
    - req_ready=1.
    - On accept: k=0, v=0, i=0, acc_a=acc_b=0; go to RACE.
  - RACE (one stage per cycle, i = 0..STAGES-1):
    - c_k[i]=0: acc_a += d_top[i]; acc_b += d_bot[i].
    - c_k[i]=1: acc_a' = acc_b + d_bot[i]; acc_b' = acc_a + d_top[i].
    - Accumulator width DELAY_W + clog2(STAGES) + 1; no overflow possible.
    - After i=STAGES-1, go to ARB.
  - ARB (1 cycle):
    - j = NOISE_EN ? noise[NOISE_W-1:0] : 0.
    - Vote = 1 if acc_a < acc_b + j, else 0. A tie gives 0.
    - Add the vote to ones_k; clear acc and i.
    - If v < VOTES-1: v++, go to RACE.
    - Else:
      - response[k] = (ones_k > VOTES/2).
      - resp_unstable[k] = (ones_k != 0 && ones_k != VOTES).
      - Clear ones_k; v=0.
      - If k < RESP_BITS-1: k++, go to RACE; else go to DONE.
  - DONE:
    - resp_valid=1; response and resp_unstable held stable.
    - On resp_ready: resp_valid=0 the next cycle; go to IDLE.
- Latency: resp_valid rises exactly L = RESP_BITS*VOTES*(STAGES+1) + 1 clocks after the accepting edge.
- Throughput: req_ready is low from the accepting edge until the cycle after the resp handshake. req_valid during busy is ignored; nothing is queued.
- response/resp_unstable update bitwise during the run and are only meaningful while resp_valid=1. They are not cleared on a new accept.
- Back-pressure: DONE may be held indefinitely. The noise LFSR keeps stepping but outputs do not change.
- Reset mid-operation: abort immediately to the reset values. The in-flight challenge is lost; no resp_valid is produced.
- Same-cycle accept in the cycle DONE is left is impossible: req_ready is only asserted in IDLE.
- NOISE_EN=0: output is a pure function of (challenge, SEED), and resp_unstable is always 0.

Test Plan:
- Reset/idle: assert rst for 3 cycles mid-RACE (STAGES=4, VOTES=3, RESP_BITS=2) -> immediately req_ready=1, resp_valid=0, response=0, busy=0; no response follows.
- Latency: STAGES=4, VOTES=3, RESP_BITS=2, NOISE_EN=0, accept challenge 4'b1010 -> resp_valid rises exactly 31 cycles later; response equals the software model of the delay table and race rules.
- Determinism: NOISE_EN=0, default params, challenge 64'h0 issued twice, then 64'hFFFF_FFFF_FFFF_FFFF -> first two responses identical and equal to the model; resp_unstable=0 in all cases.
- Back-pressure/handshake: hold resp_ready=0 for 50 cycles after resp_valid -> response stable, req_ready=0. Pulse resp_ready -> resp_valid=0 and req_ready=1 next cycle. A req_valid pulse while busy is never accepted.
- Noise/vote: NOISE_EN=1, NOISE_W=4, VOTES=5, 200 random challenges -> every response bit equals the model majority given the model noise LFSR; resp_unstable matches non-unanimous votes; at least one unstable bit observed.
- Rotation: RESP_BITS=STAGES=8, challenge 8'h01 -> bit k equals the model single-bit result for challenge 8'h01 rotated left by k, for all k.

Source files
------------

// File: rtl/arbiter_puf_if.sv
// Request/response handshake bundle between a challenge source and the arbiter PUF engine.
interface arbiter_puf_if #(
    parameter int STAGES    = 64,
    parameter int RESP_BITS = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [STAGES-1:0]    challenge;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] response;
    logic [RESP_BITS-1:0] resp_unstable;
    logic                 busy;

    modport master (
        output req_valid, challenge, resp_ready,
        input  req_ready, resp_valid, response, resp_unstable, busy
    );

    modport slave (
        input  req_valid, challenge, resp_ready,
        output req_ready, resp_valid, response, resp_unstable, busy
    );
endinterface

// File: rtl/arbiter_puf_engine.sv
// Cycle-accurate N-stage arbiter PUF: one race stage per clock, rotated sub-challenges
// per response bit, majority vote over several evaluations with an instability mask.
module arbiter_puf_engine #(
    parameter int          STAGES    = 64,
    parameter int          DELAY_W   = 8,
    parameter int          RESP_BITS = 8,
    parameter int          VOTES     = 5,
    parameter int          NOISE_EN  = 1,
    parameter int          NOISE_W   = 2,
    parameter logic [31:0] SEED      = 32'hACE12024
) (
    input logic         clk,
    input logic         rst,
    arbiter_puf_if.slave bus
);

    localparam int ACC_W = DELAY_W + $clog2(STAGES) + 1;
    localparam int I_W   = $clog2(STAGES);
    localparam int K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int V_W   = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int O_W   = $clog2(VOTES + 1);

    localparam logic [I_W-1:0] I_LAST = I_W'(STAGES - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(RESP_BITS - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(VOTES - 1);
    localparam logic [O_W-1:0] O_HALF = O_W'(VOTES / 2);
    localparam logic [O_W-1:0] O_ALL  = O_W'(VOTES);

    // Delay table: odd LFSR states feed the top path, even states the bottom path.
    function automatic logic [STAGES*DELAY_W-1:0] gen_delays(input logic top_sel);
        logic [31:0]               s;
        logic [STAGES*DELAY_W-1:0] tbl;
        s   = SEED;
        tbl = '0;
        for (int n = 1; n <= 2 * STAGES; n++) begin
            s = (s >> 1) ^ (s[0] ? 32'hB4BCD35C : 32'h0);
            if (top_sel && (n % 2 == 1))
                tbl[((n - 1) / 2) * DELAY_W +: DELAY_W] = s[DELAY_W-1:0];
            else if (!top_sel && (n % 2 == 0))
                tbl[(n / 2 - 1) * DELAY_W +: DELAY_W] = s[DELAY_W-1:0];
        end
        return tbl;
    endfunction

    function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Extra bit on both sides keeps acc_b + jitter from wrapping; a tie resolves to 0.
    function automatic logic arb_vote(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                      input logic [NOISE_W-1:0] j);
        return ({1'b0, a} < ({1'b0, b} + (ACC_W + 1)'(j)));
    endfunction

    localparam logic [STAGES*DELAY_W-1:0] D_TOP = gen_delays(1'b1);
    localparam logic [STAGES*DELAY_W-1:0] D_BOT = gen_delays(1'b0);

    typedef enum logic [1:0] {IDLE, RACE, ARB, DONE} state_t;

    state_t               state_q, state_d;
    logic                 accept;
    logic [STAGES-1:0]    ch_reg;
    logic [I_W-1:0]       i_q;
    logic [V_W-1:0]       v_q;
    logic [K_W-1:0]       k_q;
    logic [ACC_W-1:0]     acc_a, acc_b;
    logic [O_W-1:0]       ones_q, ones_nxt;
    logic [15:0]          noise_q;
    logic                 resp_valid_q;
    logic [RESP_BITS-1:0] response_q, unstable_q;
    logic [ACC_W-1:0]     d_top, d_bot;
    logic [NOISE_W-1:0]   jitter;
    logic                 vote;

    assign d_top    = ACC_W'(D_TOP[i_q*DELAY_W +: DELAY_W]);
    assign d_bot    = ACC_W'(D_BOT[i_q*DELAY_W +: DELAY_W]);
    assign jitter   = (NOISE_EN != 0) ? noise_q[NOISE_W-1:0] : '0;
    assign vote     = arb_vote(acc_a, acc_b, jitter);
    assign ones_nxt = ones_q + O_W'(vote);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                state_d = RACE;
            end
            RACE: if (i_q == I_LAST) state_d = ARB;
            ARB:  if (v_q == V_LAST && k_q == K_LAST) state_d = DONE;
                  else                                 state_d = RACE;
            DONE: if (resp_valid_q && bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_reg       <= '0;
            i_q          <= '0;
            v_q          <= '0;
            k_q          <= '0;
            acc_a        <= '0;
            acc_b        <= '0;
            ones_q       <= '0;
            noise_q      <= 16'h0001;
            resp_valid_q <= 1'b0;
            response_q   <= '0;
            unstable_q   <= '0;
        end else begin
            noise_q <= lfsr16_step(noise_q);
            case (state_q)
                IDLE: if (accept) begin
                    ch_reg <= bus.challenge;
                    i_q    <= '0;
                    v_q    <= '0;
                    k_q    <= '0;
                    acc_a  <= '0;
                    acc_b  <= '0;
                    ones_q <= '0;
                end
                // Race stage: a set challenge bit crosses the two paths.
                RACE: begin
                    if (ch_reg[i_q]) begin
                        acc_a <= acc_b + d_bot;
                        acc_b <= acc_a + d_top;
                    end else begin
                        acc_a <= acc_a + d_top;
                        acc_b <= acc_b + d_bot;
                    end
                    i_q <= i_q + 1'b1;
                end
                // Arbiter stage: tally the vote, resolve the bit after the last vote.
                ARB: begin
                    acc_a <= '0;
                    acc_b <= '0;
                    i_q   <= '0;
                    if (v_q != V_LAST) begin
                        v_q    <= v_q + 1'b1;
                        ones_q <= ones_nxt;
                    end else begin
                        response_q[k_q] <= (ones_nxt > O_HALF);
                        unstable_q[k_q] <= (ones_nxt != '0) && (ones_nxt != O_ALL);
                        ones_q          <= '0;
                        v_q             <= '0;
                        if (k_q != K_LAST) begin
                            k_q    <= k_q + 1'b1;
                            ch_reg <= {ch_reg[STAGES-2:0], ch_reg[STAGES-1]};
                        end
                    end
                end
                // Response stage: valid rises one cycle after entry, drops after the handshake.
                DONE: begin
                    if (!resp_valid_q)        resp_valid_q <= 1'b1;
                    else if (bus.resp_ready)  resp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.response      = response_q;
    assign bus.resp_unstable = unstable_q;

endmodule
